// File: rtl/decode_pkg.sv
// Shared CPU constants for the decode stage: ALU op codes, major opcodes,
// the decoded-result record and small decode helpers (package cpu_consts).
package cpu_consts;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [63:0] opr_a;
    logic [63:0] opr_b;
    op_e         op_sel;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        illegal;
  } dec_res_t;

  // Neutral result: what reset and illegal instructions leave behind
  localparam dec_res_t DEC_RES_IDLE = '{
    opr_a:   '0,
    opr_b:   '0,
    op_sel:  OP_ADD,
    rd_addr: '0,
    rd_wen:  1'b0,
    illegal: 1'b0
  };

  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  // funct3 -> ALU op; alt selects SUB/SRA variants
  function automatic op_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? OP_SUB : OP_ADD;
      3'd1:    return OP_SLL;
      3'd2:    return OP_SLT;
      3'd3:    return OP_SLTU;
      3'd4:    return OP_XOR;
      3'd5:    return alt ? OP_SRA : OP_SRL;
      3'd6:    return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// Handshake and operand bus of the decode stage. The slave modport is the
// decode block; the master modport is the fetch/regfile/execute side.
interface decode_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [63:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] opr_a_o;
  logic [63:0] opr_b_o;
  logic [3:0]  op_sel_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;
  logic        illegal_o;

  modport slave (
    input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
    output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
           opr_a_o, opr_b_o, op_sel_o, rd_addr_o, rd_wen_o, illegal_o
  );

  modport master (
    output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
    input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o,
           opr_a_o, opr_b_o, op_sel_o, rd_addr_o, rd_wen_o, illegal_o
  );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV64I decode of OP, OP-IMM, LUI and AUIPC into the
// ALU operand/op record. Anything else is reported illegal with a neutral
// result so it can travel down the pipe harmlessly.
module decode_comb
  import cpu_consts::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  output dec_res_t    res
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;
  logic       legal;
  dec_res_t   raw;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign f6  = instr[31:26];

  // Field decode and legality check per major opcode
  always_comb begin
    raw   = DEC_RES_IDLE;
    legal = 1'b0;
    case (opc)
      OPC_OP: begin
        raw.opr_a = rs1_data;
        raw.opr_b = rs2_data;
        if (f7 == 7'b0000000) begin
          legal      = 1'b1;
          raw.op_sel = alu_op(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
          legal      = 1'b1;
          raw.op_sel = alu_op(f3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        raw.opr_a = rs1_data;
        raw.opr_b = sext12(instr[31:20]);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          // RV64 shifts: 6-bit shamt, funct6 picks logical/arithmetic
          raw.opr_b = {58'd0, instr[25:20]};
          if (f6 == 6'b000000) begin
            legal      = 1'b1;
            raw.op_sel = alu_op(f3, 1'b0);
          end else if (f6 == 6'b010000 && f3 == 3'd5) begin
            legal      = 1'b1;
            raw.op_sel = OP_SRA;
          end
        end else begin
          legal      = 1'b1;
          raw.op_sel = alu_op(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        legal     = 1'b1;
        raw.opr_a = '0;
        raw.opr_b = {{32{instr[31]}}, instr[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        legal     = 1'b1;
        raw.opr_a = pc;
        raw.opr_b = {{32{instr[31]}}, instr[31:12], 12'h000};
      end
      default: legal = 1'b0;
    endcase
    if (instr[1:0] != 2'b11) legal = 1'b0;
  end

  // Attach destination or collapse to the neutral illegal result
  always_comb begin
    res = raw;
    if (legal) begin
      res.rd_addr = instr[11:7];
      res.rd_wen  = (instr[11:7] != 5'd0);
      res.illegal = 1'b0;
    end else begin
      res         = DEC_RES_IDLE;
      res.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode.sv
// Decode stage: handshake and result storage around decode_comb.
// Build option DECODE_SKID_EN: 2-entry skid buffer with a registered
// in_ready_o; otherwise a single output register with combinational ready.
module decode
  import cpu_consts::*;
(
  input logic    clk,
  input logic    resetn,
  decode_if.slave bus
);

  dec_res_t dec_res;
  dec_res_t out_q;
  logic     out_valid_q;
  logic     in_ready;
  logic     accept;
  logic     pop;

  decode_comb u_comb (
    .instr    (bus.instr_i),
    .pc       (bus.pc_i),
    .rs1_data (bus.rs1_data_i),
    .rs2_data (bus.rs2_data_i),
    .res      (dec_res)
  );

  assign bus.rs1_addr_o = bus.instr_i[19:15];
  assign bus.rs2_addr_o = bus.instr_i[24:20];

  assign accept = bus.in_valid_i & in_ready;
  assign pop    = out_valid_q & bus.out_ready_i;

`ifdef DECODE_SKID_EN
  dec_res_t skid_q;
  logic     skid_valid_q;
  logic     in_ready_q;

  assign in_ready = in_ready_q;

  // Head/skid storage; ready is precomputed from next-cycle skid occupancy,
  // and since ready implies an empty skid, accept never meets a full skid
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_q        <= DEC_RES_IDLE;
      skid_q       <= DEC_RES_IDLE;
    end else begin
      in_ready_q <= ~skid_valid_q;
      case ({accept, pop})
        2'b11: out_q <= dec_res;
        2'b10: begin
          if (out_valid_q) begin
            skid_q       <= dec_res;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
          end else begin
            out_q       <= dec_res;
            out_valid_q <= 1'b1;
          end
        end
        2'b01: begin
          if (skid_valid_q) begin
            out_q        <= skid_q;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic rst_done_q;

  assign in_ready = rst_done_q & (~out_valid_q | bus.out_ready_i);

  // Single output register, refilled in the same cycle it drains
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= DEC_RES_IDLE;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        out_q       <= dec_res;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.opr_a_o     = out_q.opr_a;
  assign bus.opr_b_o     = out_q.opr_b;
  assign bus.op_sel_o    = out_q.op_sel;
  assign bus.rd_addr_o   = out_q.rd_addr;
  assign bus.rd_wen_o    = out_q.rd_wen;
  assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: reset state, instruction classes, illegal
// encodings, backpressure ordering/stability and mid-stream reset.
module tb_decode;
  import cpu_consts::*;

  logic clk = 1'b0;
  logic resetn;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  decode_if bus ();

  decode u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    bus.instr_i     = ins;
    bus.pc_i        = pc;
    bus.rs1_data_i  = r1;
    bus.rs2_data_i  = r2;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    int acc;
    int dlv;
    int held;
    logic exp_rdy;
    logic acc_fire;
    logic dlv_fire;
    logic [11:0] imm;
    logic [4:0]  rdn;

    resetn          = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.instr_i     = 32'h0000_0013;
    bus.pc_i        = '0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) step();

    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_in_ready",  bus.in_ready_o,  0);
    chk("rst_op_sel",    bus.op_sel_o,    OP_ADD);
    chk("rst_rd_wen",    bus.rd_wen_o,    0);
    chk("rst_illegal",   bus.illegal_o,   0);
    chk("rst_opr_a",     bus.opr_a_o,     0);
    chk("rst_opr_b",     bus.opr_b_o,     0);
    chk("rst_rd_addr",   bus.rd_addr_o,   0);

    resetn = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready_o, 1);

    // ADDI x1,x2,-1
    issue(32'hFFF1_0093, 64'h0, 64'd5, 64'd0);
    chk("addi_valid",  bus.out_valid_o, 1);
    chk("addi_rs1",    bus.rs1_addr_o,  2);
    chk("addi_opr_a",  bus.opr_a_o,     5);
    chk("addi_opr_b",  bus.opr_b_o,     64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_op",     bus.op_sel_o,    OP_ADD);
    chk("addi_rd",     bus.rd_addr_o,   1);
    chk("addi_wen",    bus.rd_wen_o,    1);
    chk("addi_ill",    bus.illegal_o,   0);

    // SUB x3,x1,x2
    issue(32'h4020_81B3, 64'h0, 64'd100, 64'd30);
    chk("sub_rs1",   bus.rs1_addr_o, 1);
    chk("sub_rs2",   bus.rs2_addr_o, 2);
    chk("sub_op",    bus.op_sel_o,   OP_SUB);
    chk("sub_rd",    bus.rd_addr_o,  3);
    chk("sub_opr_a", bus.opr_a_o,    100);
    chk("sub_opr_b", bus.opr_b_o,    30);

    // SRAI x5,x6,63
    issue(32'h43F3_5293, 64'h0, 64'h8000_0000_0000_0000, 64'd0);
    chk("srai_op",   bus.op_sel_o, OP_SRA);
    chk("srai_opr_b", bus.opr_b_o, 63);
    chk("srai_rd",   bus.rd_addr_o, 5);

    // AUIPC x7,0x12345 at pc 0x1000
    issue(32'h1234_5397, 64'h1000, 64'd0, 64'd0);
    chk("auipc_opr_a", bus.opr_a_o,  64'h1000);
    chk("auipc_opr_b", bus.opr_b_o,  64'h1234_5000);
    chk("auipc_op",    bus.op_sel_o, OP_ADD);
    chk("auipc_rd",    bus.rd_addr_o, 7);

    // LUI x1,0x80000
    issue(32'h8000_00B7, 64'h1000, 64'd9, 64'd0);
    chk("lui_opr_a", bus.opr_a_o, 0);
    chk("lui_opr_b", bus.opr_b_o, 64'hFFFF_FFFF_8000_0000);
    chk("lui_wen",   bus.rd_wen_o, 1);

    // Illegal encodings
    issue(32'hFFFF_FFFF, 64'h0, 64'd7, 64'd7);
    chk("ill_ff_flag",  bus.illegal_o, 1);
    chk("ill_ff_wen",   bus.rd_wen_o,  0);
    chk("ill_ff_opr_a", bus.opr_a_o,   0);
    chk("ill_ff_valid", bus.out_valid_o, 1);
    issue(32'h0000_000B, 64'h0, 64'd7, 64'd7);
    chk("ill_0b_flag", bus.illegal_o, 1);
    chk("ill_0b_wen",  bus.rd_wen_o,  0);
    issue(32'h0220_81B3, 64'h0, 64'd7, 64'd7);
    chk("ill_f7_flag", bus.illegal_o, 1);
    chk("ill_f7_op",   bus.op_sel_o,  OP_ADD);
    issue(32'h4000_9093, 64'h0, 64'd7, 64'd7);
    chk("ill_f6_flag", bus.illegal_o, 1);

    // ADD x0,x1,x2: legal but no write
    issue(32'h0020_8033, 64'h0, 64'd1, 64'd2);
    chk("addx0_wen", bus.rd_wen_o,  0);
    chk("addx0_ill", bus.illegal_o, 0);

    // Drain output stage
    step();
    chk("drain_valid", bus.out_valid_o, 0);

    // Backpressure: 4 ADDIs back-to-back, out_ready low 3 cycles
    acc = 0;
    dlv = 0;
    for (int cyc = 0; cyc < 40 && dlv < 4; cyc++) begin
      held = acc - dlv;
      imm  = 12'(acc);
      rdn  = 5'(acc + 1);
      bus.in_valid_i  = (acc < 4);
      bus.instr_i     = {imm, 5'd0, 3'b000, rdn, 7'b0010011};
      bus.rs1_data_i  = 64'h100 + 64'(acc);
      bus.out_ready_i = (cyc >= 3);
`ifdef DECODE_SKID_EN
      exp_rdy = (held < 2);
`else
      exp_rdy = (held == 0) || (cyc >= 3);
`endif
      #1;
      chk("bp_in_ready",  bus.in_ready_o,  exp_rdy);
      chk("bp_out_valid", bus.out_valid_o, held > 0);
      if (held > 0) begin
        chk("bp_opr_a", bus.opr_a_o,   64'h100 + 64'(dlv));
        chk("bp_opr_b", bus.opr_b_o,   64'(dlv));
        chk("bp_rd",    bus.rd_addr_o, 64'(dlv + 1));
      end
      acc_fire = bus.in_valid_i && exp_rdy;
      dlv_fire = (held > 0) && bus.out_ready_i;
      step();
      if (acc_fire) acc++;
      if (dlv_fire) dlv++;
    end
    bus.in_valid_i = 1'b0;
    chk("bp_delivered", 64'(dlv), 4);
    chk("bp_accepted",  64'(acc), 4);

    // Reset with output held and a new instruction pending
    bus.out_ready_i = 1'b0;
    bus.instr_i     = 32'hFFF1_0093;
    bus.rs1_data_i  = 64'd5;
    bus.in_valid_i  = 1'b1;
    step();
    chk("hold_valid", bus.out_valid_o, 1);
    bus.instr_i = 32'h1234_5397;
    resetn      = 1'b0;
    step();
    chk("mid_rst_valid",    bus.out_valid_o, 0);
    chk("mid_rst_in_ready", bus.in_ready_o,  0);
    chk("mid_rst_opr_a",    bus.opr_a_o,     0);
    chk("mid_rst_wen",      bus.rd_wen_o,    0);
    resetn         = 1'b1;
    bus.in_valid_i = 1'b0;
    step();
    chk("rerst_in_ready", bus.in_ready_o,  1);
    chk("rerst_valid",    bus.out_valid_o, 0);

    // SLT x4,x1,x2 after reset
    issue(32'h0020_A233, 64'h0, 64'd11, 64'd22);
    chk("slt_valid", bus.out_valid_o, 1);
    chk("slt_op",    bus.op_sel_o,    OP_SLT);
    chk("slt_opr_a", bus.opr_a_o,     11);
    chk("slt_opr_b", bus.opr_b_o,     22);
    chk("slt_rd",    bus.rd_addr_o,   4);
    step();
    chk("slt_drain", bus.out_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: resetn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: in_valid_i/in_ready_o  in/out  1/1  instruction handshake; instr_i  input  32  RV64I instruction; pc_i  input  64  its PC.
REQ-004 SHALL have ports: rs1_addr_o/rs2_addr_o  output  5/5  regfile read addresses, combinational from instr_i[19:15]/[24:20]; rs1_data_i/rs2_data_i  input  64/64  same-cycle read data.
REQ-005 SHALL have ports: out_valid_o/out_ready_i  out/in  1/1  execute handshake; opr_a_o/opr_b_o  output  64/64  ALU operands; op_sel_o  output  4  ALU op code; rd_addr_o  output  5; rd_wen_o  output  1; illegal_o  output  1.

Function
REQ-006 SHALL accept an instruction when in_valid_i & in_ready_o on a rising edge; SHALL transfer an output when out_valid_o & out_ready_i.
REQ-007 SHALL present decoded results exactly 1 cycle after acceptance when the output stage is empty; all outputs registered.
REQ-008 SHALL hold opr_a_o, opr_b_o, op_sel_o, rd_addr_o, rd_wen_o, illegal_o stable while out_valid_o=1 and out_ready_i=0.
REQ-009 SHALL decode OP (0110011): funct3/funct7 -> OP_ADD, OP_SUB (f7=0100000), OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA (f7=0100000), OP_OR, OP_AND; opr_a=rs1_data, opr_b=rs2_data.
REQ-010 SHALL decode OP-IMM (0010011): opr_b = sign-extended imm[31:20]; shifts use 6-bit shamt instr[25:20], SRAI when instr[31:26]=010000, SLLI/SRLI when 000000.
REQ-011 SHALL decode LUI: op_sel=OP_ADD, opr_a=0, opr_b = sign-extend({instr[31:12],12'h0}); AUIPC: opr_a=pc_i, same opr_b.
REQ-012 SHALL set rd_wen_o=1 for legal instructions with rd!=0, else 0.
REQ-013 SHALL flag illegal_o=1 for any other opcode, unused funct7/funct6 pattern, or instr[1:0]!=11; then op_sel=OP_ADD, operands 0, rd_wen_o=0; illegal results flow through the same handshake.
REQ-014 SHALL, with output full and out_ready_i=1 in the same cycle as a new acceptance, replace the output register with no bubble (back-to-back throughput 1/cycle).
REQ-015 SHALL never drop or duplicate an instruction under any in_valid_i/out_ready_i pattern.

Reset
REQ-016 SHALL, while resetn=0 at a clock edge, clear out_valid_o, illegal_o, rd_wen_o, opr_a_o, opr_b_o, rd_addr_o to 0, op_sel_o to OP_ADD, discarding any held or in-flight instruction.
REQ-017 SHALL drive in_ready_o=0 during reset and 1 in the first cycle after resetn returns high.

Configuration
REQ-018 SHALL, with DECODE_SKID_EN defined, include a 2-entry skid buffer: in_ready_o is a register output (no combinational path from out_ready_i), asserted while fewer than 2 entries held.
REQ-019 SHALL, without DECODE_SKID_EN, use a single output register with in_ready_o = ~out_valid_o | out_ready_i (combinational).
REQ-020 SHALL keep latency (REQ-007) and throughput identical in both configurations.

Structure
REQ-021 SHALL take OP_* codes and opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC) from package cpu_consts; the decoded-result struct (opr_a, opr_b, op_sel, rd_addr, rd_wen, illegal) SHALL be a typedef in cpu_consts.
REQ-022 SHALL place combinational decode in sub-module decode_comb (instr, pc, rs data -> result struct); decode holds only handshake/storage.

Verification
REQ-023 SHALL test ADDI x1,x2,-1 (0xFFF10093), rs1_data=5 -> next cycle opr_a=5, opr_b=0xFFFFFFFFFFFFFFFF, op_sel=OP_ADD, rd=1, rd_wen=1.
REQ-024 SHALL test SUB x3,x1,x2 (0x402081B3) -> op_sel=OP_SUB, rs1_addr_o=1, rs2_addr_o=2, rd=3; SRAI x5,x6,63 (0x43F35293) -> OP_SRA, opr_b=63.
REQ-025 SHALL test AUIPC x7,0x12345 (0x12345397), pc=0x1000 -> opr_a=0x1000, opr_b=0x12345000; LUI 0x80000 -> opr_b=0xFFFFFFFF80000000.
REQ-026 SHALL test 0xFFFFFFFF and 0x0000000B -> illegal_o=1, rd_wen=0; ADD x0,x1,x2 -> rd_wen=0.
REQ-027 SHALL test backpressure: 4 back-to-back instructions, out_ready_i low 3 cycles then high -> all 4 delivered in order, outputs stable while stalled, in_ready_o per REQ-018/019.
REQ-028 SHALL test resetn=0 with output held and input valid -> next cycle out_valid_o=0; post-reset instruction delivered correctly.
